spi_cfg_seq: RTL

Configuration sequencer that drives the team's single-word SPI master. On a start pulse it walks a ROM table of NUM_ENTRIES serial words and issues each through the master's ac/din/rdy/vld handshake, inserting a fixed gap between words. It sits between the board bring-up logic and the SPI master, and reports busy, done and error status.

---
 rtl/spi_cfg_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_cfg_seq.sv
// Walks a ROM table of SPI words through the single-word SPI master with a fixed inter-word gap.
// Optional readback verify of written words: define SPI_CFG_VERIFY_EN.
module spi_cfg_seq #(
  parameter int DATA_BITS   = 26,
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W      = 4,
  parameter int GAP_CYCLES  = 100,
  parameter int TIMEOUT     = 4095,
  parameter int RD_BIT      = 25,
  parameter int CMP_BITS    = 8
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W-1:0]    err_idx,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [DATA_BITS-1:0] rom_data,
  output logic                 spi_ac,
  output logic [DATA_BITS-1:0] spi_din,
  input  logic [DATA_BITS-1:0] spi_rdata,
  input  logic                 spi_vld,
  input  logic                 spi_rdy
);

  localparam int TW       = $clog2(TIMEOUT + 1);
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT_VLD, S_WAIT_RDY, S_GAP, S_DONE
  } state_t;

  state_t               r_state, w_next;
  logic [ADDR_W-1:0]    r_idx, r_err_idx;
  logic                 r_done, r_err, r_ac;
  logic [DATA_BITS-1:0] r_din;
  logic [TW-1:0]        r_tmo;
  logic [GW-1:0]        r_gap;

  logic w_start_ok, w_ac_set, w_adv, w_rb_set, w_err_set, w_done_set;
  logic w_last, w_tmo, w_need_rb, w_rb_bad;
  logic w_unused;

  assign w_last   = (r_idx == LAST);
  assign w_tmo    = (r_tmo == TW'(TIMEOUT - 1));
  assign w_unused = ^spi_rdata ^ (RD_BIT != 0) ^ (CMP_BITS != 0);

`ifdef SPI_CFG_VERIFY_EN
  localparam logic [DATA_BITS-1:0] RD_MASK = DATA_BITS'(1) << RD_BIT;
  logic r_rb;  // current word is the readback copy of a write

  assign w_need_rb = !r_rb && !r_din[RD_BIT];
  assign w_rb_bad  = r_rb && (spi_rdata[CMP_BITS-1:0] != r_din[CMP_BITS-1:0]);

  always_ff @(posedge mclk or posedge reset) begin
    if (reset)                   r_rb <= 1'b0;
    else if (w_start_ok || w_adv) r_rb <= 1'b0;
    else if (w_rb_set)           r_rb <= 1'b1;
  end
`else
  assign w_need_rb = 1'b0;
  assign w_rb_bad  = 1'b0;
`endif

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = start ? S_FETCH : S_IDLE;
      S_FETCH:        w_next = S_LOAD;
      S_LOAD:         w_next = S_ISSUE;
      S_ISSUE:        if (spi_rdy) w_next = S_WAIT_VLD;
      S_WAIT_VLD: begin
        if (spi_vld)    w_next = S_WAIT_RDY;
        else if (w_tmo) w_next = S_DONE;
      end
      S_WAIT_RDY: begin
        if (spi_rdy) begin
          if (!w_need_rb && w_last) w_next = S_DONE;
          else if (GAP_CYCLES == 0) w_next = w_need_rb ? S_LOAD : S_FETCH;
          else                      w_next = S_GAP;
        end
      end
      S_GAP:   if (r_gap == '0) w_next = w_need_rb ? S_LOAD : S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    w_start_ok = start && !busy;
    w_ac_set   = (r_state == S_ISSUE) && spi_rdy;
    w_adv      = (r_state == S_WAIT_RDY || r_state == S_GAP) && (w_next == S_FETCH);
    w_rb_set   = (r_state == S_WAIT_RDY || r_state == S_GAP) && (w_next == S_LOAD);
    // vld wins over timeout; on vld only a readback mismatch can flag
    w_err_set  = (r_state == S_WAIT_VLD) && (spi_vld ? w_rb_bad : w_tmo);
    w_done_set = (w_next == S_DONE) && (r_state != S_DONE);
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_idx     <= '0;
      r_err_idx <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ac      <= 1'b0;
      r_din     <= '0;
      r_tmo     <= '0;
      r_gap     <= '0;
    end else begin
      r_ac <= w_ac_set;
      if (w_start_ok) begin
        r_idx     <= '0;
        r_done    <= 1'b0;
        r_err     <= 1'b0;
        r_err_idx <= '0;
      end else if (w_adv) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_done_set) r_done <= 1'b1;
      if (w_err_set) begin
        r_err <= 1'b1;
        if (!r_err) r_err_idx <= r_idx;
      end
      if (r_state == S_LOAD) begin
`ifdef SPI_CFG_VERIFY_EN
        r_din <= r_rb ? (r_din | RD_MASK) : rom_data;
`else
        r_din <= rom_data;
`endif
      end
      if (w_ac_set)                  r_tmo <= '0;
      else if (r_state == S_WAIT_VLD) r_tmo <= r_tmo + 1'b1;
      if (r_state == S_WAIT_RDY)               r_gap <= GW'(GAP_LOAD);
      else if (r_state == S_GAP && r_gap != '0) r_gap <= r_gap - 1'b1;
    end
  end

  assign done     = r_done;
  assign err      = r_err;
  assign err_idx  = r_err_idx;
  assign rom_addr = r_idx;
  assign spi_ac   = r_ac;
  assign spi_din  = r_din;

endmodule
